// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for a four-approach intersection (min/max green, yellow, all-red).
// Define PED_SERVICE_EN to add the btnC pedestrian walk phase; without it btnC is ignored.
module traffic_phase_scheduler #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned MIN_GREEN = 3,
    parameter int unsigned MAX_GREEN = 8,
    parameter int unsigned YELLOW    = 2,
    parameter int unsigned ALL_RED   = 1,
    parameter int unsigned WALK      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw,
    input  logic        btnC,
    output logic [1:0]  phase,
    output logic        green,
    output logic        yellow,
    output logic        ped_walk,
    output logic [15:0] led
);

    localparam int unsigned   PW           = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [7:0]    ALL_RED_LAST = 8'(ALL_RED - 1);
    localparam logic [7:0]    YELLOW_LAST  = 8'(YELLOW - 1);
    localparam logic [7:0]    WALK_LAST    = 8'(WALK - 1);
    localparam logic [8:0]    MIN_E        = 9'(MIN_GREEN);
    localparam logic [8:0]    MAX_E        = 9'(MAX_GREEN);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_PED    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [7:0]    timer_q, timer_d;
    logic [PW-1:0] presc_q;
    logic          tick;
    logic          ped_pend;
    logic          unused_in;

    logic [3:0]    demand;
    logic [1:0]    cand;
    logic [1:0]    winner;
    logic          found;
    logic          own_dem;
    logic          other_dem;
    logic [8:0]    elapsed;

    logic [15:0]   lanes;
    logic [15:0]   led_d;
    logic          green_d;
    logic          yellow_d;
    logic          ped_walk_d;

    assign demand    = sw[3:0];
    assign tick      = (presc_q == PRESC_LAST);
    assign own_dem   = demand[phase_q];
    assign other_dem = |(demand & ~(4'b0001 << phase_q));
    assign elapsed   = {1'b0, timer_q} + 9'd1;

    // Free-running: interval starts are not aligned to the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

`ifdef PED_SERVICE_EN
    logic [1:0] btn_sync_q;
    logic       btn_prev_q;
    logic       btn_rise;
    logic       ped_pend_q;

    assign btn_rise  = btn_sync_q[1] & ~btn_prev_q;
    assign ped_pend  = ped_pend_q;
    assign unused_in = ^sw[15:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_q <= '0;
            btn_prev_q <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], btnC};
            btn_prev_q <= btn_sync_q[1];
            if (state_d == ST_PED && state_q != ST_PED) begin
                ped_pend_q <= 1'b0;
            end else if (btn_rise && state_q != ST_PED) begin
                ped_pend_q <= 1'b1;
            end
        end
    end
`else
    assign ped_pend  = 1'b0;
    assign unused_in = ^{sw[15:4], btnC};
`endif

    // Round-robin search starting just after the last granted phase.
    always_comb begin
        found  = 1'b0;
        winner = phase_q;
        cand   = phase_q;
        for (int k = 1; k <= 4; k++) begin
            cand = phase_q + 2'(k);
            if (!found && demand[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (tick) begin
            unique case (state_q)
                ST_ALLRED: begin
                    if (timer_q >= ALL_RED_LAST) begin
                        if (ped_pend) begin
                            state_d = ST_PED;
                        end else if (found) begin
                            state_d = ST_GREEN;
                            phase_d = winner;
                        end
                    end
                end
                ST_GREEN: begin
                    if (elapsed >= MIN_E && (ped_pend || other_dem) &&
                        (elapsed >= MAX_E || !own_dem)) begin
                        state_d = ST_YELLOW;
                    end
                end
                ST_YELLOW: begin
                    if (timer_q >= YELLOW_LAST) state_d = ST_ALLRED;
                end
                ST_PED: begin
                    if (timer_q >= WALK_LAST) state_d = ST_ALLRED;
                end
                default: state_d = ST_ALLRED;
            endcase
        end
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && timer_q != 8'hFF) begin
            timer_d = timer_q + 8'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    always_comb begin
        unique case (phase_q)
            2'd0:    lanes = 16'hC0C0;
            2'd1:    lanes = 16'h2020;
            2'd2:    lanes = 16'h0E00;
            default: lanes = 16'h000E;
        endcase
        led_d      = '0;
        green_d    = 1'b0;
        yellow_d   = 1'b0;
        ped_walk_d = 1'b0;
        unique case (state_q)
            ST_GREEN: begin
                led_d   = lanes;
                green_d = 1'b1;
            end
            ST_YELLOW: begin
                led_d    = lanes | 16'h0100;
                yellow_d = 1'b1;
            end
            ST_PED: begin
                led_d      = 16'h0010;
                ped_walk_d = 1'b1;
            end
            default: led_d = '0;
        endcase
    end

    // Lamp outputs are decoded from the current state, so they trail a state change by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ALLRED;
            phase_q  <= 2'd3;
            timer_q  <= '0;
            phase    <= 2'd3;
            led      <= '0;
            green    <= 1'b0;
            yellow   <= 1'b0;
            ped_walk <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            phase    <= phase_q;
            led      <= led_d;
            green    <= green_d;
            yellow   <= yellow_d;
            ped_walk <= ped_walk_d;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler with a 4-clk tick: MIN_GREEN=2, MAX_GREEN=4, YELLOW=1, ALL_RED=1, WALK=2.
// Expected lamp segments {kind, phase, led, length in clk} are queued and matched against each lamp change.
module tb_traffic_phase_scheduler;
    localparam int W = 28;
    localparam logic [1:0] K_AR  = 2'd0;
    localparam logic [1:0] K_G   = 2'd1;
    localparam logic [1:0] K_Y   = 2'd2;
    localparam logic [1:0] K_PED = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic        btnC;
    logic [1:0]  phase;
    logic        green;
    logic        yellow;
    logic        ped_walk;
    logic [15:0] led;

    int tests  = 0;
    int failed = 0;
    logic [W-1:0] exp_q[$];

    traffic_phase_scheduler #(
        .TICK_DIV (4),
        .MIN_GREEN(2),
        .MAX_GREEN(4),
        .YELLOW   (1),
        .ALL_RED  (1),
        .WALK     (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .btnC    (btnC),
        .phase   (phase),
        .green   (green),
        .yellow  (yellow),
        .ped_walk(ped_walk),
        .led     (led)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] seg(input logic [1:0] kind, input logic [1:0] ph,
                                         input logic [15:0] lamps, input logic [7:0] len);
        return {kind, ph, lamps, len};
    endfunction

    function automatic logic [2:0] flags_of(input logic [1:0] kind);
        case (kind)
            K_G:     return 3'b100;
            K_Y:     return 3'b010;
            K_PED:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // driver: wait (bounded) for the lamp field to change; cyc counts negedges waited
    task automatic wait_change(input int budget, output bit to, output int cyc);
        logic [15:0] prev;
        prev = led;
        to   = 1'b1;
        cyc  = 0;
        while (to && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (led !== prev) to = 1'b0;
        end
    endtask

    task automatic apply_reset(input logic [15:0] sw_val);
        @(negedge clk);
        rst_n = 1'b0;
        sw    = sw_val;
        btnC  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sw    = 16'h0000;
        btnC  = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (led !== 16'h0000) begin failed++; $display("FAIL reset_led: got %h required 0000", led); end
        tests++;
        if (phase !== 2'd3) begin failed++; $display("FAIL reset_phase: got %0d required 3", phase); end
        tests++;
        if ({green, yellow, ped_walk} !== 3'b000) begin
            failed++; $display("FAIL reset_flags: got %b required 000", {green, yellow, ped_walk});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            tests++;
            if ({led, phase, green} !== {16'h0000, 2'd3, 1'b0}) begin
                failed++;
                $display("FAIL idle_no_demand: clk %0d led=%h phase=%0d green=%b required 0000/3/0",
                         i, led, phase, green);
            end
        end
    endtask

    task automatic test_single_demand;
        bit to;
        int cyc;
        sw = 16'h0001;
        wait_change(20, to, cyc);
        tests++;
        if (to) begin failed++; $display("FAIL single_grant: no lamp change, required led c0c0"); end
        tests++;
        if (led !== 16'hC0C0) begin failed++; $display("FAIL single_led: got %h required c0c0", led); end
        tests++;
        if (phase !== 2'd0) begin failed++; $display("FAIL single_phase: got %0d required 0", phase); end
        tests++;
        if ({green, yellow, ped_walk} !== 3'b100) begin
            failed++; $display("FAIL single_flags: got %b required 100", {green, yellow, ped_walk});
        end
        wait_change(120, to, cyc);
        tests++;
        if (!to) begin failed++; $display("FAIL single_rest: lamps changed to %h after %0d clk, required steady c0c0", led, cyc); end
    endtask

    task automatic test_alternating;
        bit to;
        int cyc;
        int prev_len;
        logic [W-1:0] e;
        sw = 16'h0005;
        exp_q.push_back(seg(K_Y,  2'd0, 16'hC1C0, 8'd4));
        exp_q.push_back(seg(K_AR, 2'd0, 16'h0000, 8'd4));
        exp_q.push_back(seg(K_G,  2'd2, 16'h0E00, 8'd16));
        exp_q.push_back(seg(K_Y,  2'd2, 16'h0F00, 8'd4));
        exp_q.push_back(seg(K_AR, 2'd2, 16'h0000, 8'd4));
        exp_q.push_back(seg(K_G,  2'd0, 16'hC0C0, 8'd16));
        exp_q.push_back(seg(K_Y,  2'd0, 16'hC1C0, 8'd4));
        exp_q.push_back(seg(K_AR, 2'd0, 16'h0000, 8'd4));
        exp_q.push_back(seg(K_G,  2'd2, 16'h0E00, 8'd0));
        prev_len = 0;
        while (exp_q.size() > 0) begin
            wait_change(200, to, cyc);
            e = exp_q.pop_front();
            tests++;
            if (to) begin
                failed++;
                $display("FAIL alt_timeout: no lamp change in 200 clk, required led=%h", e[23:8]);
                exp_q.delete();
            end else begin
                tests++;
                if (led !== e[23:8]) begin failed++; $display("FAIL alt_led: got %h required %h", led, e[23:8]); end
                tests++;
                if (phase !== e[25:24]) begin failed++; $display("FAIL alt_phase: got %0d required %0d", phase, e[25:24]); end
                tests++;
                if ({green, yellow, ped_walk} !== flags_of(e[27:26])) begin
                    failed++; $display("FAIL alt_flags: got %b required %b", {green, yellow, ped_walk}, flags_of(e[27:26]));
                end
                if (prev_len != 0) begin
                    tests++;
                    if (cyc != prev_len) begin failed++; $display("FAIL alt_length: segment lasted %0d clk required %0d", cyc, prev_len); end
                end
            end
            prev_len = int'(e[7:0]);
        end
    endtask

    task automatic test_demand_switch;
        bit to;
        int cyc;
        int prev_len;
        logic [W-1:0] e;
        apply_reset(16'h0001);
        exp_q.push_back(seg(K_G,  2'd0, 16'hC0C0, 8'd12));
        exp_q.push_back(seg(K_Y,  2'd0, 16'hC1C0, 8'd4));
        exp_q.push_back(seg(K_AR, 2'd0, 16'h0000, 8'd4));
        exp_q.push_back(seg(K_G,  2'd3, 16'h000E, 8'd0));
        rst_n = 1'b1;
        // own demand drops and phase 3 rises between the 2nd and 3rd green ticks
        fork
            begin
                repeat (14) @(negedge clk);
                sw = 16'h0008;
            end
        join_none
        prev_len = 5;
        while (exp_q.size() > 0) begin
            wait_change(200, to, cyc);
            e = exp_q.pop_front();
            tests++;
            if (to) begin
                failed++;
                $display("FAIL switch_timeout: no lamp change in 200 clk, required led=%h", e[23:8]);
                exp_q.delete();
            end else begin
                tests++;
                if (led !== e[23:8]) begin failed++; $display("FAIL switch_led: got %h required %h", led, e[23:8]); end
                tests++;
                if (phase !== e[25:24]) begin failed++; $display("FAIL switch_phase: got %0d required %0d", phase, e[25:24]); end
                tests++;
                if ({green, yellow, ped_walk} !== flags_of(e[27:26])) begin
                    failed++; $display("FAIL switch_flags: got %b required %b", {green, yellow, ped_walk}, flags_of(e[27:26]));
                end
                if (prev_len != 0) begin
                    tests++;
                    if (cyc != prev_len) begin failed++; $display("FAIL switch_length: segment lasted %0d clk required %0d", cyc, prev_len); end
                end
            end
            prev_len = int'(e[7:0]);
        end
    endtask

`ifdef PED_SERVICE_EN
    task automatic test_ped_service;
        bit to;
        int cyc;
        int prev_len;
        logic [W-1:0] e;
        apply_reset(16'h0002);
        exp_q.push_back(seg(K_G,   2'd1, 16'h2020, 8'd8));
        exp_q.push_back(seg(K_Y,   2'd1, 16'h2120, 8'd4));
        exp_q.push_back(seg(K_AR,  2'd1, 16'h0000, 8'd4));
        exp_q.push_back(seg(K_PED, 2'd1, 16'h0010, 8'd8));
        exp_q.push_back(seg(K_AR,  2'd1, 16'h0000, 8'd4));
        exp_q.push_back(seg(K_G,   2'd1, 16'h2020, 8'd0));
        rst_n = 1'b1;
        // first press during phase-1 green, second press while the walk is showing
        fork
            begin
                repeat (6) @(negedge clk);
                btnC = 1'b1;
                @(negedge clk);
                btnC = 1'b0;
                repeat (14) @(negedge clk);
                btnC = 1'b1;
                repeat (3) @(negedge clk);
                btnC = 1'b0;
            end
        join_none
        prev_len = 5;
        while (exp_q.size() > 0) begin
            wait_change(200, to, cyc);
            e = exp_q.pop_front();
            tests++;
            if (to) begin
                failed++;
                $display("FAIL ped_timeout: no lamp change in 200 clk, required led=%h", e[23:8]);
                exp_q.delete();
            end else begin
                tests++;
                if (led !== e[23:8]) begin failed++; $display("FAIL ped_led: got %h required %h", led, e[23:8]); end
                tests++;
                if (phase !== e[25:24]) begin failed++; $display("FAIL ped_phase: got %0d required %0d", phase, e[25:24]); end
                tests++;
                if ({green, yellow, ped_walk} !== flags_of(e[27:26])) begin
                    failed++; $display("FAIL ped_flags: got %b required %b", {green, yellow, ped_walk}, flags_of(e[27:26]));
                end
                if (prev_len != 0) begin
                    tests++;
                    if (cyc != prev_len) begin failed++; $display("FAIL ped_length: segment lasted %0d clk required %0d", cyc, prev_len); end
                end
            end
            prev_len = int'(e[7:0]);
        end
        wait_change(60, to, cyc);
        tests++;
        if (!to) begin failed++; $display("FAIL ped_second_press: lamps changed to %h, required steady 2020", led); end
    endtask
`else
    task automatic test_btn_ignored;
        bit to;
        int cyc;
        apply_reset(16'h0002);
        rst_n = 1'b1;
        wait_change(40, to, cyc);
        tests++;
        if (to || led !== 16'h2020 || phase !== 2'd1) begin
            failed++; $display("FAIL btn_grant: led=%h phase=%0d required 2020/1", led, phase);
        end
        btnC = 1'b1;
        repeat (2) @(negedge clk);
        btnC = 1'b0;
        wait_change(60, to, cyc);
        tests++;
        if (!to) begin failed++; $display("FAIL btn_ignored: lamps changed to %h, required steady 2020", led); end
    endtask
`endif

    task automatic test_reset_mid_yellow;
        bit to;
        int cyc;
        apply_reset(16'h0005);
        rst_n = 1'b1;
        wait_change(40, to, cyc);
        tests++;
        if (to || cyc != 5 || led !== 16'hC0C0) begin
            failed++; $display("FAIL midy_first_green: led=%h after %0d clk required c0c0 after 5", led, cyc);
        end
        wait_change(40, to, cyc);
        tests++;
        if (to || cyc != 16 || led !== 16'hC1C0) begin
            failed++; $display("FAIL midy_yellow: led=%h after %0d clk required c1c0 after 16", led, cyc);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (led !== 16'h0000) begin failed++; $display("FAIL midy_reset_led: got %h required 0000", led); end
        tests++;
        if (phase !== 2'd3) begin failed++; $display("FAIL midy_reset_phase: got %0d required 3", phase); end
        tests++;
        if ({green, yellow, ped_walk} !== 3'b000) begin
            failed++; $display("FAIL midy_reset_flags: got %b required 000", {green, yellow, ped_walk});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_change(40, to, cyc);
        tests++;
        if (to || cyc != 5 || led !== 16'hC0C0 || phase !== 2'd0) begin
            failed++; $display("FAIL midy_resume: led=%h phase=%0d after %0d clk required c0c0/0 after 5", led, phase, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single_demand();
        test_alternating();
        test_demand_switch();
`ifdef PED_SERVICE_EN
        test_ped_service();
`else
        test_btn_ignored();
`endif
        test_reset_mid_yellow();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase scheduler for the four-approach intersection. Replaces the fixed 5-second rotation with a round-robin arbiter that grants green only to approaches with pending vehicle demand, enforces min/max green, yellow and all-red clearance intervals, and inserts a pedestrian walk phase on request. Drives the same 16-bit LED lamp field and sits between the board switches/buttons and the LEDs.

## Interface
- TICK_DIV, 100_000_000: clk cycles per timing tick (1 s at 100 MHz); ≥2
- MIN_GREEN, 3: minimum green, ticks (1..255)
- MAX_GREEN, 8: green after which a phase yields if other demand exists (≥MIN_GREEN, ≤255)
- YELLOW, 2: yellow interval, ticks (1..255)
- ALL_RED, 1: all-red clearance, ticks (1..255)
- WALK, 4: pedestrian walk interval, ticks (1..255)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sw  in  16  sw[3:0] = demand level for phases 0..3; sw[15:4] unused
- btnC  in  1  pedestrian request button, asynchronous
- phase  out  2  phase currently granted (or last granted)
- green  out  1  granted phase in green
- yellow  out  1  granted phase in yellow
- ped_walk  out  1  pedestrian walk active
- led  out  16  lamp field

## Operation
- Phases: 0 = N+S left+straight, 1 = N+S right, 2 = West all, 3 = East all.
- Prescaler: 0..TICK_DIV-1, `tick` single-cycle pulse at TICK_DIV-1. Free-running; never restarted by state changes.
- 8-bit interval timer cleared on every state entry, incremented on `tick`, saturating at 255.
- btnC: two-flop synchronizer, rising-edge detect → sets `ped_pend`. Cleared on PED entry. Edges while in PED ignored.
- FSM states: ALLRED, GREEN, YELLOW, PED.
  - ALLRED: on `tick` with timer==ALL_RED-1 (or later): if `ped_pend` → PED; else round-robin search phase+1, +2, +3, +0 (mod 4) for first set sw bit → GREEN, phase ← winner; no demand → remain in ALLRED, re-evaluated each tick, phase unchanged.
  - GREEN: let e = timer+1 at a tick. Leave → YELLOW at tick when e ≥ MIN_GREEN and (`ped_pend` or any other phase's demand set) and (e ≥ MAX_GREEN or own demand low). Otherwise stay (rests indefinitely with no competing demand).
  - YELLOW: tick with timer==YELLOW-1 → ALLRED.
  - PED: tick with timer==WALK-1 → ALLRED; phase unchanged, so search resumes after last vehicle phase.
- Demand is level-sensitive, sampled only at decision ticks; no latching.
- Outputs registered, decoded from FSM state/phase.
  - GREEN: phase 0 → led[15:14]=11, led[7:6]=11; phase 1 → led[13]=1, led[5]=1; phase 2 → led[11:9]=111; phase 3 → led[3:1]=111.
  - YELLOW: same lane bits as GREEN for that phase plus led[8]=1.
  - PED: led[4]=1 only. ALLRED: led=0.
- green/yellow/ped_walk one-hot or all zero (all zero in ALLRED).

## Timing
- Reset (async assert): state ALLRED, phase=3, timer=0, prescaler=0, ped_pend=0, sync flops 0; led=0, green=yellow=ped_walk=0. First decision at ALL_RED ticks after release; phase 0 searched first.
- State change happens on the clk edge where `tick`=1; outputs reflect the new state one clk later.
- btnC edge to ped_pend set: 3 clk.
- Interval lengths exact to prescaler granularity: first interval after entry may be short by up to TICK_DIV-1 clk (prescaler is free-running).
- Reset mid-operation: immediate return to reset values, no yellow completion.

## Configuration
- PED_SERVICE_EN defined: pedestrian logic as above.
- Not defined: synchronizer, ped_pend and PED state omitted; btnC ignored; ped_walk tied 0; led[4] always 0; ALLRED goes straight to phase search.

## Test plan
(TICK_DIV=4, MIN_GREEN=2, MAX_GREEN=4, YELLOW=1, ALL_RED=1, WALK=2)
- Reset, sw=0 for 40 clk → led=0, phase=3, green=0 throughout.
- sw=0001 only → GREEN phase 0, led=16'hC0C0, stays green indefinitely (>100 clk).
- sw=0101 steady → phase sequence 0,2,0,2; each green exactly 4 ticks, yellow led[8]=1 for 1 tick, 1 all-red tick between.
- sw=0001, drop bit 0 and raise bit 3 at tick 3 of green → yellow at that tick, then phase 3, led=16'h000E.
- btnC pulse during phase-1 green with sw=0010 → yellow after MIN_GREEN, all-red, PED 2 ticks led=16'h0010, then back to phase 1; second press during PED ignored.
- Assert rst_n=0 mid-YELLOW → led=0, phase=3 same cycle; resumes per reset sequence after release.
